// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, window FSM states and tap indexing for the 3x3 window path.
package conv_pkg;
  localparam int DATA_W  = 12;
  localparam int COORD_W = 11;
  typedef enum logic [1:0] {FILL0, FILL1, STREAM} win_state_t;
  function automatic int tap_idx(input int r, input int c);
    return 3 * r + c;
  endfunction
endpackage

// File: rtl/line_buf.sv
// line_buf: one image row of pixels, synchronous write with asynchronous read-old-data.
module line_buf #(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int DEPTH  = 640
) (
  input  logic                        clk,
  input  logic                        we_i,
  input  logic [conv_pkg::COORD_W-1:0] addr_i,
  input  logic [DATA_W-1:0]           wdata_i,
  output logic [DATA_W-1:0]           rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[addr_i] <= wdata_i;
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/gray_window3x3.sv
// gray_window3x3: streaming 3x3 window generator over two line buffers.
// Optional GRAY_WIN_COORD_EN adds registered window-centre coordinates.
module gray_window3x3 #(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int IMG_W  = 640
) (
  input  logic                        iCLK,
  input  logic                        iRST,
  input  logic [DATA_W-1:0]           iDATA,
  input  logic                        iDVAL,
  input  logic [conv_pkg::COORD_W-1:0] iX_Cont,
  input  logic [conv_pkg::COORD_W-1:0] iY_Cont,
  output logic [9*DATA_W-1:0]         oWIN,
  output logic                        oDVAL
`ifdef GRAY_WIN_COORD_EN
  ,
  output logic [conv_pkg::COORD_W-1:0] oX_Cont,
  output logic [conv_pkg::COORD_W-1:0] oY_Cont
`endif
);
  import conv_pkg::*;
  logic [COORD_W-1:0] col_q, col_d, row_q, row_d, col_c, row_c;
  win_state_t st_q, st_d, st_c;
  logic [9*DATA_W-1:0] win_q, win_d;
  logic dval_q, dval_d, fs, eor;
  logic [DATA_W-1:0] lb1_rd, lb2_rd;
  logic [DATA_W-1:0] newc [3];
  line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
    .clk(iCLK), .we_i(iDVAL), .addr_i(col_c), .wdata_i(iDATA), .rdata_o(lb1_rd)
  );
  line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb2 (
    .clk(iCLK), .we_i(iDVAL), .addr_i(col_c), .wdata_i(lb1_rd), .rdata_o(lb2_rd)
  );
  // Frame start overrides the current position and state for this very pixel.
  always_comb begin
    fs      = iDVAL && iX_Cont == '0 && iY_Cont == '0;
    col_c   = fs ? '0 : col_q;
    row_c   = fs ? '0 : row_q;
    st_c    = fs ? FILL0 : st_q;
    eor     = col_c == COORD_W'(IMG_W - 1);
    col_d   = !iDVAL ? col_q : eor ? '0 : col_c + 1'b1;
    row_d   = !iDVAL ? row_q : (eor && row_c != '1) ? row_c + 1'b1 : row_c;
    st_d    = !iDVAL ? st_q : !eor ? st_c : st_c == FILL0 ? FILL1 : STREAM;
    dval_d  = iDVAL && st_c == STREAM && col_c >= COORD_W'(2);
    newc[0] = lb2_rd;
    newc[1] = lb1_rd;
    newc[2] = iDATA;
    win_d   = win_q;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win_d[tap_idx(r, c)*DATA_W +: DATA_W] = !iDVAL ? win_q[tap_idx(r, c)*DATA_W +: DATA_W] :
                                                c == 2 ? newc[r] : win_q[tap_idx(r, c + 1)*DATA_W +: DATA_W];
  end
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      col_q  <= '0;
      row_q  <= '0;
      st_q   <= FILL0;
      win_q  <= '0;
      dval_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      st_q   <= st_d;
      win_q  <= win_d;
      dval_q <= dval_d;
    end
  assign oWIN  = win_q;
  assign oDVAL = dval_q;
`ifdef GRAY_WIN_COORD_EN
  logic [COORD_W-1:0] x_q, y_q;
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      x_q <= '0;
      y_q <= '0;
    end else if (dval_d) begin
      x_q <= col_c - 1'b1;
      y_q <= row_c - 1'b1;
    end
  assign oX_Cont = x_q;
  assign oY_Cont = y_q;
`endif
endmodule

// File: tb/tb_gray_window3x3.sv
// tb_gray_window3x3: randomized frames against an image-array reference model.
module tb_gray_window3x3;
  localparam int W  = 4;
  localparam int DW = 12;
  logic iCLK = 1'b0, iRST = 1'b1, iDVAL = 1'b0;
  logic [DW-1:0] iDATA = '0;
  logic [10:0] iX_Cont = '0, iY_Cont = '0;
  logic [9*DW-1:0] oWIN;
  logic oDVAL;
`ifdef GRAY_WIN_COORD_EN
  logic [10:0] oX_Cont, oY_Cont;
`endif
  gray_window3x3 #(.DATA_W(DW), .IMG_W(W)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL),
    .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .oWIN(oWIN), .oDVAL(oDVAL)
`ifdef GRAY_WIN_COORD_EN
    , .oX_Cont(oX_Cont), .oY_Cont(oY_Cont)
`endif
  );
  always #5 iCLK = ~iCLK;
  int vectors = 0, miscompares = 0, n = 0, obs_cnt = 0;
  bit chk_first = 0;
  logic [DW-1:0] pix [16][W];
  logic [9*DW-1:0] first_win;
  task automatic check_cnt(input string tag, input int exp);
    vectors++;
    assert (obs_cnt === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs_cnt, exp);
    end
  endtask
  task automatic step(input bit v, input logic [DW-1:0] d, input int x, input int y);
    bit ev = 0;
    int mx = 0, my = 0;
    logic [9*DW-1:0] ew = '0;
    iDVAL = v; iDATA = d; iX_Cont = 11'(x); iY_Cont = 11'(y);
    if (v) begin
      if (x == 0 && y == 0) n = 0;
      mx = n % W; my = n / W;
      if (my < 16) pix[my][mx] = d;
      ev = my >= 2 && my < 16 && mx >= 2;
      if (ev)
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) ew[(3*r+c)*DW +: DW] = pix[my-2+r][mx-2+c];
      n++;
    end
    @(posedge iCLK); #1;
    vectors++;
    assert (oDVAL === ev) else begin
      miscompares++;
      $error("FAIL dval observed=%0b expected=%0b at n=%0d", oDVAL, ev, n);
    end
    if (oDVAL === 1'b1) obs_cnt++;
    if (ev) begin
      vectors++;
      assert (oWIN === ew) else begin
        miscompares++;
        $error("FAIL win observed=%h expected=%h", oWIN, ew);
      end
      if (chk_first) begin
        chk_first = 0;
        vectors++;
        assert (oWIN === first_win) else begin
          miscompares++;
          $error("FAIL first_win observed=%h expected=%h", oWIN, first_win);
        end
      end
`ifdef GRAY_WIN_COORD_EN
      vectors++;
      assert (oX_Cont === 11'(mx - 1) && oY_Cont === 11'(my - 1)) else begin
        miscompares++;
        $error("FAIL coord observed=%0d,%0d expected=%0d,%0d", oX_Cont, oY_Cont, mx - 1, my - 1);
      end
`endif
    end
  endtask
  // mode 0: pixel 16y+x, no gaps; mode 1: random, alternating idle; mode 2: random, random gaps
  task automatic frame(input int mode, input int npix);
    for (int i = 0; i < npix; i++) begin
      if ((mode == 1 && i > 0) || (mode == 2 && $urandom_range(0, 2) == 0))
        step(0, DW'($urandom), 1, 1);
      step(1, mode == 0 ? DW'(16 * (i / W) + i % W) : DW'($urandom), i % W, i / W);
    end
    step(0, '0, 1, 1);
  endtask
  initial begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) first_win[(3*r+c)*DW +: DW] = DW'(16 * r + c);
    repeat (2) @(posedge iCLK);
    #1;
    vectors += 2;
    assert (oDVAL === 1'b0) else begin miscompares++; $error("FAIL reset_dval observed=%0b expected=0", oDVAL); end
    assert (oWIN === '0) else begin miscompares++; $error("FAIL reset_win observed=%h expected=0", oWIN); end
    iRST = 1'b0;
    obs_cnt = 0; chk_first = 1;
    frame(0, 16);
    check_cnt("count_ramp", 4);
    obs_cnt = 0;
    frame(1, 16);
    check_cnt("count_alt", 4);
    obs_cnt = 0;
    frame(2, 24);
    check_cnt("count_6row", 8);
    frame(2, 12);
    obs_cnt = 0;
    frame(2, 16);
    check_cnt("count_fs_row3", 4);
    frame(2, 7);
    obs_cnt = 0;
    frame(2, 16);
    check_cnt("count_fs_lastcol", 4);
    frame(0, 12);
    #2 iRST = 1'b1;
    #1;
    vectors += 2;
    assert (oDVAL === 1'b0) else begin miscompares++; $error("FAIL async_rst_dval observed=%0b expected=0", oDVAL); end
    assert (oWIN === '0) else begin miscompares++; $error("FAIL async_rst_win observed=%h expected=0", oWIN); end
    @(posedge iCLK); #1 iRST = 1'b0;
    obs_cnt = 0; chk_first = 1;
    frame(0, 16);
    check_cnt("count_after_rst", 4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
